// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;
  localparam logic [63:0] PC_STEP      = 64'd4;
  localparam logic [31:0] SQUASH_INSTR = 32'd0;

  typedef enum logic {RUN, FAULT} fetch_state_t;
endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: redirect/stall controls, ROM port and IF/ID outputs.
interface instr_fetch_if;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic        id_valid;
  logic        fault;

  modport master (
    input  stall, redirect, redirect_pc, imem_instr,
    output imem_addr, id_instr, id_pc, id_valid, fault
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_instr,
    input  imem_addr, id_instr, id_pc, id_valid, fault
  );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, hold and squash controls.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        hold,
  input  logic        squash,
  input  logic [31:0] instr,
  input  logic [63:0] pc,
  output logic [31:0] id_instr,
  output logic [63:0] id_pc,
  output logic        id_valid
);

  // Neither load nor hold: payload is kept but marked invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_instr <= SQUASH_INSTR;
      id_pc    <= '0;
      id_valid <= 1'b0;
    end else if (squash) begin
      id_instr <= SQUASH_INSTR;
      id_pc    <= '0;
      id_valid <= 1'b0;
    end else if (load) begin
      id_instr <= instr;
      id_pc    <= pc;
      id_valid <= 1'b1;
    end else if (!hold) begin
      id_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, next-PC mux, bounds check and RUN/FAULT FSM.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int          IMEM_SIZE = 1024
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);

  fetch_state_t state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic         pc_bad;
  logic         load, hold, squash;

  assign pc_bad = (pc_q[1:0] != 2'b00) ||
                  (pc_q + 64'd3 >= 64'(IMEM_SIZE));

  assign bus.imem_addr = pc_q;
  assign bus.fault     = (state_q == FAULT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Priority in RUN: redirect, fault check, stall, advance.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    hold    = 1'b0;
    squash  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.redirect) begin
          pc_d   = bus.redirect_pc;
          squash = 1'b1;
        end else if (pc_bad) begin
          state_d = FAULT;
        end else if (bus.stall) begin
          hold = 1'b1;
        end else begin
          pc_d = pc_q + PC_STEP;
          load = 1'b1;
        end
      end
      FAULT: begin
      end
      default: begin
      end
    endcase
  end

  if_id_reg u_if_id (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .hold     (hold),
    .squash   (squash),
    .instr    (bus.imem_instr),
    .pc       (pc_q),
    .id_instr (bus.id_instr),
    .id_pc    (bus.id_pc),
    .id_valid (bus.id_valid)
  );

  a_valid_aligned : assert property (
    @(posedge clk) disable iff (reset)
    bus.id_valid |-> (bus.id_pc[1:0] == 2'b00)
  );

  a_fault_sticky : assert property (
    @(posedge clk) disable iff (reset)
    $past(bus.fault) |-> bus.fault
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a spec-level fetch model.
module tb_instr_fetch;

  localparam int IMEM = 1024;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   fault_age;

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC  (64'd0),
    .IMEM_SIZE (IMEM)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(logic [63:0] a);
    return (a[31:0] ^ 32'h5A5A_0F0F) * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  assign bus.imem_instr = rom_word(bus.imem_addr);

  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic [63:0] m_idpc;
  logic        m_valid;
  logic        m_fault;

  function automatic bit pc_illegal(logic [63:0] p);
    return (p % 64'd4 != 0) || (p + 64'd3 >= 64'(IMEM));
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc    <= 64'd0;
      m_instr <= 32'd0;
      m_idpc  <= 64'd0;
      m_valid <= 1'b0;
      m_fault <= 1'b0;
    end else if (m_fault) begin
      m_valid <= 1'b0;
    end else if (bus.redirect) begin
      m_pc    <= bus.redirect_pc;
      m_instr <= 32'd0;
      m_idpc  <= 64'd0;
      m_valid <= 1'b0;
    end else if (pc_illegal(m_pc)) begin
      m_fault <= 1'b1;
      m_valid <= 1'b0;
    end else if (!bus.stall) begin
      m_instr <= rom_word(m_pc);
      m_idpc  <= m_pc;
      m_valid <= 1'b1;
      m_pc    <= m_pc + 64'd4;
    end
  end

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("fault", 64'(bus.fault), 64'(m_fault));
    chk("id_valid", 64'(bus.id_valid), 64'(m_valid));
    chk("id_pc", bus.id_pc, m_idpc);
    chk("id_instr", 64'(bus.id_instr), 64'(m_instr));
  end

  task automatic cyc(bit st, bit rd, logic [63:0] rpc);
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(0, 0, 64'd0);
    cyc(0, 0, 64'd0);
    reset = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    fault_age = 0;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 64'd0;
    #1;
    chk("rst_addr", bus.imem_addr, 64'd0);
    chk("rst_valid", 64'(bus.id_valid), 64'd0);
    do_reset();
    chk("rst_fault", 64'(bus.fault), 64'd0);
    chk("rst_idpc", bus.id_pc, 64'd0);

    cyc(0, 0, 64'd0);
    chk("sl_addr1", bus.imem_addr, 64'd4);
    chk("sl_idpc1", bus.id_pc, 64'd0);
    chk("sl_valid1", 64'(bus.id_valid), 64'd1);
    chk("sl_instr1", 64'(bus.id_instr), 64'(rom_word(64'd0)));
    cyc(0, 0, 64'd0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 64'd0);
    chk("st_addr", bus.imem_addr, 64'd8);
    chk("st_idpc", bus.id_pc, 64'd4);
    chk("st_valid", 64'(bus.id_valid), 64'd1);
    cyc(0, 0, 64'd0);
    chk("st_resume", bus.id_pc, 64'd8);
    chk("st_instr", 64'(bus.id_instr), 64'(rom_word(64'd8)));
    cyc(0, 0, 64'd0);
    chk("pre_rd", bus.imem_addr, 64'd16);

    cyc(1, 1, 64'd40);
    chk("rd_addr", bus.imem_addr, 64'd40);
    chk("rd_valid", 64'(bus.id_valid), 64'd0);
    cyc(0, 0, 64'd0);
    chk("rd_idpc", bus.id_pc, 64'd40);
    chk("rd_valid2", 64'(bus.id_valid), 64'd1);

    cyc(0, 1, 64'd42);
    chk("mis_nofault", 64'(bus.fault), 64'd0);
    cyc(0, 0, 64'd0);
    chk("mis_fault", 64'(bus.fault), 64'd1);
    for (int i = 0; i < 10; i++)
      cyc(1'($urandom), 1'($urandom), 64'd0);
    chk("mis_hold", bus.imem_addr, 64'd42);
    chk("mis_valid", 64'(bus.id_valid), 64'd0);
    do_reset();
    chk("mis_rst_f", 64'(bus.fault), 64'd0);
    chk("mis_rst_pc", bus.imem_addr, 64'd0);

    cyc(0, 1, 64'd1012);
    for (int i = 0; i < 3; i++) cyc(0, 0, 64'd0);
    chk("ub_pc", bus.imem_addr, 64'd1024);
    chk("ub_cap", bus.id_pc, 64'd1020);
    chk("ub_nofault", 64'(bus.fault), 64'd0);
    cyc(0, 0, 64'd0);
    chk("ub_fault", 64'(bus.fault), 64'd1);
    chk("ub_idpc", bus.id_pc, 64'd1020);
    chk("ub_valid", 64'(bus.id_valid), 64'd0);
    do_reset();

    for (int i = 0; i < 6; i++) cyc(0, 0, 64'd0);
    chk("ar_pre", bus.imem_addr, 64'd24);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_pc", bus.imem_addr, 64'd0);
    chk("ar_valid", 64'(bus.id_valid), 64'd0);
    chk("ar_fault", 64'(bus.fault), 64'd0);
    cyc(0, 0, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      logic [63:0] rpc;
      int sel;
      sel = $urandom_range(0, 19);
      if (sel < 16) rpc = {52'd0, 8'($urandom), 2'b00} + 64'd0;
      else if (sel == 16) rpc = 64'($urandom_range(0, 1023));
      else if (sel == 17) rpc = 64'd1008 + 64'($urandom_range(0, 4) * 4);
      else rpc = {$urandom, $urandom};
      if (m_fault) fault_age++;
      if (fault_age > 6 && $urandom_range(0, 3) == 0) begin
        fault_age = 0;
        reset = 1'b1;
        cyc(0, 0, 64'd0);
        reset = 1'b0;
      end else begin
        cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, rpc);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
